wb_regfile: RTL and testbench

- Write-back end of the 5-stage pipeline. Consumes the phase-5 control outputs (MemtoReg, RegWrite, RegDst) with the phase-5 data values.
- Selects the write-back value, writes it into an 8-entry general register file, and serves two combinational decode-stage read ports with same-cycle write-through bypass.
- Also provides a registered last-write record for the forwarding unit, plus a retire counter for debug and performance.

---
 rtl/wb_regfile_if.sv | 33 +++
 rtl/wb_regfile.sv | 71 +++++++
 tb/tb_wb_regfile.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Write-back / register-file bus: phase-5 controls and data in, decode read
// ports, write-back value, last-write record and retire counter out.
interface wb_regfile_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              memtoreg;
    logic              regwrite;
    logic [2:0]        regdst;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W-1:0] mem_data;
    logic [2:0]        ra_addr;
    logic [2:0]        rb_addr;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] wb_data;
    logic              lw_valid;
    logic [2:0]        lw_dst;
    logic [DATA_W-1:0] lw_data;
    logic [CNT_W-1:0]  retire_cnt;

    // Pipeline side: drives phase-5 controls/data and read addresses.
    modport master (
        output memtoreg, regwrite, regdst, alu_data, mem_data, ra_addr, rb_addr,
        input  ra_data, rb_data, wb_data, lw_valid, lw_dst, lw_data, retire_cnt
    );

    // Register-file side.
    modport slave (
        input  memtoreg, regwrite, regdst, alu_data, mem_data, ra_addr, rb_addr,
        output ra_data, rb_data, wb_data, lw_valid, lw_dst, lw_data, retire_cnt
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it into an 8-entry
// register file, serves two bypassed read ports, and keeps a registered
// last-write record plus a wrapping retire counter.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);
    localparam int NREGS = 8;

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [DATA_W-1:0] wb_next;
    logic              commit;
    logic              lw_valid_reg;
    logic [2:0]        lw_dst_reg;
    logic [DATA_W-1:0] lw_data_reg;
    logic [CNT_W-1:0]  retire_cnt_reg;

    // Write-back mux, valid regardless of regwrite.
    assign wb_next = bus.memtoreg ? bus.mem_data : bus.alu_data;
    // A write only takes effect outside reset; this also gates the bypass.
    assign commit  = rst_n && bus.regwrite;

    // One register per entry; r0 is an ordinary writable register.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_regs
        // Clear on reset, otherwise load when this entry is the commit target.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                regs_reg[gi] <= '0;
            end else if (bus.regwrite && (bus.regdst == 3'(gi))) begin
                regs_reg[gi] <= wb_next;
            end
        end
    end

    // Last-write record for the forwarding unit; dst/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lw_valid_reg <= 1'b0;
            lw_dst_reg   <= '0;
            lw_data_reg  <= '0;
        end else begin
            lw_valid_reg <= bus.regwrite;
            if (bus.regwrite) begin
                lw_dst_reg  <= bus.regdst;
                lw_data_reg <= wb_next;
            end
        end
    end

    // Retired-write counter, wraps naturally with no saturation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_reg <= '0;
        end else if (bus.regwrite) begin
            retire_cnt_reg <= retire_cnt_reg + 1'b1;
        end
    end

    assign bus.wb_data    = wb_next;
    // Same-cycle write-through so decode sees the value being committed.
    assign bus.ra_data    = (commit && bus.regdst == bus.ra_addr) ? wb_next : regs_reg[bus.ra_addr];
    assign bus.rb_data    = (commit && bus.regdst == bus.rb_addr) ? wb_next : regs_reg[bus.rb_addr];
    assign bus.lw_valid   = lw_valid_reg;
    assign bus.lw_dst     = lw_dst_reg;
    assign bus.lw_data    = lw_data_reg;
    assign bus.retire_cnt = retire_cnt_reg;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the stimulus process predicts each cycle's
// outputs from a simple array model and queues them; a negedge monitor pops
// and compares against the DUT.
`timescale 1ns/1ps
module tb_wb_regfile;
    logic clk;
    logic rst_n;

    wb_regfile_if #(.DATA_W(16), .CNT_W(16)) bus ();

    wb_regfile #(.DATA_W(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          check_state;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] wb;
        logic        lw_valid;
        logic [2:0]  lw_dst;
        logic [15:0] lw_data;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: contents as of the most recent edge.
    int m_regs[8];
    bit m_known    = 0;
    bit m_lw_valid = 0;
    int m_lw_dst   = 0;
    int m_lw_data  = 0;
    int m_cnt      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("wb_data", 32'(bus.wb_data), 32'(e.wb));
            if (e.check_state) begin
                check("ra_data",    32'(bus.ra_data),    32'(e.ra));
                check("rb_data",    32'(bus.rb_data),    32'(e.rb));
                check("lw_valid",   32'(bus.lw_valid),   32'(e.lw_valid));
                check("lw_dst",     32'(bus.lw_dst),     32'(e.lw_dst));
                check("lw_data",    32'(bus.lw_data),    32'(e.lw_data));
                check("retire_cnt", 32'(bus.retire_cnt), 32'(e.cnt));
            end
        end
    end

    // One cycle of stimulus: apply inputs, queue the prediction, advance model.
    task automatic drive(input bit rst, input bit m2r, input bit we, input int dst,
                         input int alu, input int mem, input int ra, input int rb,
                         input string tag);
        exp_t e;
        int   wb;
        bit   byp;
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus.memtoreg  = m2r;
        bus.regwrite  = we;
        bus.regdst    = dst[2:0];
        bus.alu_data  = alu[15:0];
        bus.mem_data  = mem[15:0];
        bus.ra_addr   = ra[2:0];
        bus.rb_addr   = rb[2:0];

        wb  = m2r ? mem : alu;
        byp = rst && we;
        e.check_state = m_known;
        e.wb       = wb[15:0];
        e.ra       = (byp && dst == ra) ? wb[15:0] : m_regs[ra][15:0];
        e.rb       = (byp && dst == rb) ? wb[15:0] : m_regs[rb][15:0];
        e.lw_valid = m_lw_valid;
        e.lw_dst   = m_lw_dst[2:0];
        e.lw_data  = m_lw_data[15:0];
        e.cnt      = m_cnt[15:0];
        sb_q.push_back(e);
        if (tag != "")
            $display("txn %-10s rst_n=%0d we=%0d m2r=%0d dst=%0d wb=%04h ra=%0d->%04h rb=%0d->%04h cnt=%0d",
                     tag, rst, we, m2r, dst, wb, ra, e.ra, rb, e.rb, m_cnt);

        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_known    = 1;
            m_lw_valid = 0;
            m_lw_dst   = 0;
            m_lw_data  = 0;
            m_cnt      = 0;
        end else begin
            m_lw_valid = we;
            if (we) begin
                m_regs[dst] = wb;
                m_lw_dst    = dst;
                m_lw_data   = wb;
                m_cnt       = (m_cnt + 1) % 65536;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int d, n;
        rst_n = 1'b0;
        bus.memtoreg = 0; bus.regwrite = 0; bus.regdst = 0;
        bus.alu_data = 0; bus.mem_data = 0; bus.ra_addr = 0; bus.rb_addr = 0;

        // Reset with a write pending: the write must be dropped.
        drive(0, 0, 1, 3, 'hBEEF, 0, 3, 3, "rst0");
        drive(0, 0, 1, 3, 'hBEEF, 0, 3, 3, "rst1");
        drive(1, 0, 0, 3, 'hBEEF, 0, 3, 0, "post_rst");
        // ALU write-back with bypass, then from the array.
        drive(1, 0, 1, 5, 'h1234, 'hFFFF, 5, 0, "alu_wr");
        drive(1, 0, 0, 5, 0, 0, 5, 5, "alu_rd");
        // Load write-back with both ports hitting the destination.
        drive(1, 1, 1, 2, 0, 'hA5A5, 2, 2, "ld_dual");
        drive(1, 1, 1, 2, 0, 'hA5A5, 2, 4, "ld_rb4");
        // Back-to-back writes to the same register.
        drive(1, 0, 1, 7, 'h0001, 0, 7, 0, "r7_a");
        drive(1, 0, 1, 7, 'h0002, 0, 7, 0, "r7_b");
        drive(1, 0, 0, 0, 0, 0, 7, 2, "r7_rd");
        // Reset mid-stream discards the write presented with it.
        drive(1, 0, 1, 1, 'h5555, 0, 1, 1, "r1_wr");
        drive(0, 0, 1, 1, 'h6666, 0, 1, 1, "r1_rst");
        drive(1, 0, 0, 1, 0, 0, 1, 5, "r1_rd");
        // r0 is writable.
        drive(1, 0, 1, 0, 'h0BAD, 0, 0, 1, "r0_wr");
        drive(1, 0, 0, 0, 0, 0, 0, 0, "r0_rd");

        // Random traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 65535),
                  $urandom_range(0, 7), $urandom_range(0, 7), "");
        end
        $display("txn random   2000 cycles issued");

        // Counter wrap: 65535 commits reach 0xFFFF, the next returns to 0.
        drive(0, 0, 0, 0, 0, 0, 0, 0, "wrap_rst");
        n = 65536;
        for (int i = 0; i < n; i++) begin
            d = $urandom_range(0, 7);
            drive(1, $urandom_range(0, 1), 1, d, $urandom_range(0, 65535), $urandom_range(0, 65535),
                  $urandom_range(0, 7), d, (i >= n - 2) ? "wrap_edge" : "");
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1, "wrap_done");

        // Let the monitor drain the scoreboard, bounded.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
